// File: rtl/controlador_ordenador_pkg.sv
// Shared types and constants for the streaming sort front-end.
// The pad constants are the fill values that sort to the tail of a frame.
package controlador_ordenador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SORT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_N     = 8;

    localparam logic [DEF_WIDTH-1:0] PAD_ASC  = '1;
    localparam logic [DEF_WIDTH-1:0] PAD_DESC = '0;

endpackage

// File: rtl/controlador_ordenador.sv
// Collects a frame of up to N words, runs it through the external combinational
// sorter for SORT_LAT cycles, then streams the sorted words out.
module controlador_ordenador
    import controlador_ordenador_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int N        = DEF_N,
    parameter int SORT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    input  logic                 cresc_ou_decres,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 sort_ena,
    output logic                 sort_dir,
    output logic [N*WIDTH-1:0]   sort_in,
    input  logic [N*WIDTH-1:0]   sort_out
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    idx;
    logic [LW-1:0]    wait_cnt;
    logic             dir;
    logic [WIDTH-1:0] buf_q   [N];
    logic [WIDTH-1:0] out_buf [N];

    logic in_acc;
    logic out_acc;
    logic sort_done;
    logic load_full;

    function automatic logic [WIDTH-1:0] pad_fill(input logic d);
        return d ? {WIDTH{PAD_DESC[0]}} : {WIDTH{PAD_ASC[0]}};
    endfunction

    // Valid/ready: a word moves on a rising edge where valid && ready; a raised
    // out_valid and its out_data stay put until the consumer takes them.
    assign in_ready  = !rst && (state == IDLE || state == LOAD);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign sort_ena  = (state == SORT);
    assign sort_dir  = dir;

    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign sort_done = (state == SORT) && (wait_cnt == LW'(SORT_LAT - 1));
    assign load_full = (count == CW'(N - 1));

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (state == DRAIN) begin
            out_data = out_buf[idx[IW-1:0]];
            out_last = (idx == count - CW'(1));
        end
    end

    always_comb begin
        sort_in = '0;
        for (int k = 0; k < N; k++) begin
            sort_in[k*WIDTH +: WIDTH] = buf_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_acc) state_next = in_last ? SORT : LOAD;
            LOAD:    if (in_acc && (in_last || load_full)) state_next = SORT;
            SORT:    if (sort_done) state_next = DRAIN;
            DRAIN:   if (out_acc && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            dir      <= 1'b0;
            for (int k = 0; k < N; k++) begin
                buf_q[k]   <= {WIDTH{PAD_ASC[0]}};
                out_buf[k] <= {WIDTH{PAD_ASC[0]}};
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_acc) begin
                        dir      <= cresc_ou_decres;
                        count    <= CW'(1);
                        buf_q[0] <= in_data;
                        // Unused slots hold a value that sorts behind every real word.
                        for (int k = 1; k < N; k++) begin
                            buf_q[k] <= pad_fill(cresc_ou_decres);
                        end
                    end
                end
                LOAD: begin
                    if (in_acc) begin
                        buf_q[count[IW-1:0]] <= in_data;
                        count                <= count + CW'(1);
                    end
                end
                SORT: begin
                    if (sort_done) begin
                        wait_cnt <= '0;
                        idx      <= '0;
                        for (int k = 0; k < N; k++) begin
                            out_buf[k] <= sort_out[k*WIDTH +: WIDTH];
                        end
                    end else begin
                        wait_cnt <= wait_cnt + LW'(1);
                    end
                end
                DRAIN: begin
                    if (out_acc) begin
                        if (out_last) begin
                            idx   <= '0;
                            count <= '0;
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_ordenador.sv
// Bench for the streaming sort front-end: a behavioural sorter stands in for the
// external sorter, and a queue-based scoreboard checks the sorted output stream.
module tb_controlador_ordenador;

    localparam int W        = 9;
    localparam int N        = 8;
    localparam int SORT_LAT = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           cresc_ou_decres;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           busy;
    logic           sort_ena;
    logic           sort_dir;
    logic [N*W-1:0] sort_in;
    logic [N*W-1:0] sort_out;

    always #5 clk = ~clk;

    controlador_ordenador #(.WIDTH(W), .N(N), .SORT_LAT(SORT_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .cresc_ou_decres(cresc_ou_decres),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .sort_ena(sort_ena),
        .sort_dir(sort_dir),
        .sort_in(sort_in),
        .sort_out(sort_out)
    );

    // Stand-in for the external combinational sorter (outputs zero when disabled).
    function automatic logic [N*W-1:0] sorter_model(input logic [N*W-1:0] v, input logic d);
        logic [W-1:0]   a [N];
        logic [W-1:0]   t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
        for (int i = 0; i < N - 1; i++) begin
            for (int j = 0; j < N - 1 - i; j++) begin
                if (d ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    assign sort_out = sort_ena ? sorter_model(sort_in, sort_dir) : '0;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    logic         last_q[$];
    logic [W-1:0] frame_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_out    = 0;
    int last_acc_cyc = 0;
    int rdy_mode = 0;
    int pidx     = 0;
    bit pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=timeout_or_extra exp=event at t=%0t", name, $time);
    endtask

    // Consumer ready: always, random, or the fixed 1,0,0,1 pattern.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: begin out_ready = pat[pidx % 4]; pidx++; end
            endcase
        end
    end

    // Monitor: samples on the falling edge, pops expectations on each output transfer.
    initial begin
        logic         prev_valid;
        logic         prev_stall;
        logic [W-1:0] prev_data;
        logic [W-1:0] e;
        logic         l;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (in_valid && in_ready && in_last) last_acc_cyc = cyc;
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid) begin
                    if (!prev_valid) check("latency", 32'(cyc - last_acc_cyc), 32'(SORT_LAT + 1));
                    check("in_ready_drain", 32'(in_ready), 32'd0);
                    check("busy_drain", 32'(busy), 32'd1);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            flag_fail("unexpected_word");
                        end else begin
                            e = exp_q.pop_front();
                            l = last_q.pop_front();
                            check("out_data", 32'(out_data), 32'(e));
                            check("out_last", 32'(out_last), 32'(l));
                        end
                        n_out++;
                    end
                end
                prev_valid = out_valid;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    // Sends frame_q; the reference result is the frame itself, sorted, without padding.
    task automatic send_frame(input logic d);
        logic [W-1:0] s[$];
        int t;
        s = frame_q;
        if (d) s.rsort(); else s.sort();
        foreach (s[i]) begin
            exp_q.push_back(s[i]);
            last_q.push_back(i == s.size() - 1);
        end
        foreach (frame_q[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid        = 1'b1;
            in_data         = frame_q[i];
            in_last         = (i == frame_q.size() - 1);
            cresc_ou_decres = (i == 0) ? d : 1'($urandom_range(0, 1));
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) flag_fail("in_ready_timeout");
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (busy) flag_fail("idle_timeout");
        check("frame_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input logic d);
        send_frame(d);
        wait_idle();
    endtask

    initial begin
        int base;
        int t;
        int len;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        cresc_ou_decres = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sort_ena", 32'(sort_ena), 32'd0);
        check("rst_sort_dir", 32'(sort_dir), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("idle_in_ready", 32'(in_ready), 32'd1);

        frame_q = '{9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1};
        run_frame(1'b0);
        frame_q = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8};
        run_frame(1'b1);
        frame_q = '{9'd7, 9'd7, 9'd7, 9'd7, 9'd7, 9'd7, 9'd7, 9'd7};
        run_frame(1'b0);
        frame_q = '{9'd5, 9'h1FF, 9'd2};
        run_frame(1'b0);
        frame_q = '{9'd0};
        run_frame(1'b1);

        rdy_mode = 2;
        pidx = 0;
        frame_q = {};
        for (int i = 0; i < N; i++) frame_q.push_back(W'($urandom_range(0, 511)));
        run_frame(1'($urandom_range(0, 1)));
        rdy_mode = 0;

        frame_q = {};
        for (int i = 0; i < N; i++) frame_q.push_back(W'($urandom_range(0, 511)));
        base = n_out;
        send_frame(1'b0);
        t = 0;
        while (n_out < base + 3 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (n_out < base + 3) flag_fail("drain_start_timeout");
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_sort_ena", 32'(sort_ena), 32'd0);
        exp_q.delete();
        last_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("postrst_no_output", 32'(out_valid), 32'd0);

        frame_q = '{9'd3, 9'd1};
        run_frame(1'b0);

        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, N);
            frame_q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) frame_q.push_back($urandom_range(0, 1) ? 9'h1FF : 9'h000);
                else frame_q.push_back(W'($urandom_range(0, 511)));
            end
            run_frame(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
